data_ram_ls: RTL and testbench
==============================

DATA_RAM_LS -- requirements
Module: data_ram_ls

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 32, meaning data word width in bits; legal values are 32 and 64.
REQ-002 The block SHALL have parameter MEMDEPTH, default 1024, meaning number of DWIDTH words; power of two.
REQ-003 The block SHALL have parameter AWIDTH, default 32, meaning byte-address width.
REQ-004 The block SHALL have port clk  input  1  meaning the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n  input  1  meaning reset, asynchronous and active-low.
REQ-006 The block SHALL have port req_valid  input  1  meaning a request is present.
REQ-007 The block SHALL have port req_ready  output  1  meaning the block can accept a request this cycle.
REQ-008 The block SHALL have port req_we  input  1  meaning 1 = store, 0 = load.
REQ-009 The block SHALL have port req_size  input  2  meaning access size: 0 = byte, 1 = half, 2 = word, 3 = dword (legal only when DWIDTH=64).
REQ-010 The block SHALL have port req_unsigned  input  1  meaning zero-extend load data instead of sign-extending it.
REQ-011 The block SHALL have port req_addr  input  AWIDTH  meaning byte address.
REQ-012 The block SHALL have port req_wdata  input  DWIDTH  meaning store data, right-aligned (lane 0).
REQ-013 The block SHALL have port rsp_valid  output  1  meaning a response is present.
REQ-014 The block SHALL have port rsp_ready  input  1  meaning the consumer accepts the response.
REQ-015 The block SHALL have port rsp_rdata  output  DWIDTH  meaning the extended load result; 0 for stores and errors.
REQ-016 The block SHALL have port rsp_err  output  1  meaning the access was out-of-range or illegal-size (misaligned also, see REQ-031).

Function
REQ-017 A request SHALL be accepted when req_valid && req_ready in the same cycle.
REQ-018 req_ready SHALL equal !rsp_valid || rsp_ready; at most one response is outstanding.
REQ-019 Word index SHALL be req_addr[log2(DWIDTH/8) +: log2(MEMDEPTH)]; byte lane = the low log2(DWIDTH/8) address bits.
REQ-020 An accepted store SHALL write only the addressed bytes via byte enables; unaddressed bytes are unchanged; write data is shifted to the lane.
REQ-021 An accepted load SHALL present data exactly one cycle after acceptance: rsp_valid rises on the next edge; data is shifted down from the lane and sign- or zero-extended to DWIDTH.
REQ-022 Every accepted request, load or store, SHALL produce exactly one response.
REQ-023 rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_ready is sampled high.
REQ-024 Back-to-back operation: with rsp_ready tied high, the block SHALL accept one request per cycle, giving full throughput.
REQ-025 Response ordering: responses SHALL be returned in request order.
REQ-026 A load accepted in the cycle after a store to the same word SHALL return the post-store data.
REQ-027 Out-of-range access SHALL raise rsp_err=1 and rsp_rdata=0, with no memory write; out-of-range means req_addr >= MEMDEPTH*DWIDTH/8.
REQ-028 Illegal size SHALL raise rsp_err=1 with no write; illegal means req_size=3 when DWIDTH=32.
REQ-029 Memory contents SHALL NOT be reset; the array is inferable as block RAM.

Reset
REQ-030 While rst_n=0, outputs SHALL be: rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=1. A response pending at reset assertion SHALL be discarded. A store accepted in the same edge as reset assertion SHALL NOT be written.

Configuration
REQ-031 Macro DATA_RAM_ALIGN_CHECK_EN SHALL control misaligned-access checking; misaligned means addr not a multiple of the access size.
- Defined: a misaligned access SHALL produce rsp_err=1 and rsp_rdata=0, with no write.
- Undefined: the low address bits below the access size SHALL be ignored (forced to 0), the access completes normally, and rsp_err reflects only REQ-027/028.

Verification
REQ-032 SW 0xDEADBEEF @0x10, then LB @0x13 -> rsp_rdata=0xFFFFFFDE; LBU @0x13 -> 0x000000DE.
REQ-033 SW 0x11223344 @0x20, SH 0xAAAA @0x22, LW @0x20 -> 0xAAAA3344.
REQ-034 rsp_ready held low 3 cycles after a load -> rsp_valid and rsp_rdata stable, req_ready=0; first rsp_ready cycle -> the next request is accepted.
REQ-035 LW @0x1000 with MEMDEPTH=1024 -> rsp_err=1, rsp_rdata=0; a following LW @0x0 returns the prior contents unchanged.
REQ-036 LH @0x11 -> with DATA_RAM_ALIGN_CHECK_EN: rsp_err=1; without it: data of the half-word at 0x10, rsp_err=0.
REQ-037 rst_n pulsed low while rsp_valid=1 -> rsp_valid=0 immediately; memory retains the stored values.

Source files
------------

// File: rtl/data_ram_ls.sv
// Byte-addressable load/store data RAM with valid/ready request and response channels.
// Optional misaligned-access error checking is enabled by defining DATA_RAM_ALIGN_CHECK_EN.
module data_ram_ls #(
  parameter int unsigned DWIDTH   = 32,
  parameter int unsigned MEMDEPTH = 1024,
  parameter int unsigned AWIDTH   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned NB   = DWIDTH / 8;
  localparam int unsigned OFFW = $clog2(NB);
  localparam int unsigned IDXW = $clog2(MEMDEPTH);
  localparam logic [AWIDTH:0] MEM_BYTES = (AWIDTH+1)'(MEMDEPTH * NB);

  // Everything the response stage needs to format load data after the RAM read.
  typedef struct packed {
    logic            err;
    logic            load_ok;
    logic            uns;
    logic [1:0]      size;
    logic [OFFW-1:0] lane;
  } rsp_info_t;

  logic [DWIDTH-1:0] mem [MEMDEPTH];

  logic              accept_c;
  logic [IDXW-1:0]   idx_c;
  logic [OFFW-1:0]   lane_raw_c;
  logic [OFFW-1:0]   align_mask_c;
  logic [OFFW-1:0]   lane_c;
  logic              range_err_c;
  logic              size_err_c;
  logic              align_err_c;
  logic              err_c;
  logic [NB-1:0]     be_base_c;
  logic [NB-1:0]     be_c;
  logic [DWIDTH-1:0] wdata_sh_c;
  logic              we_c;

  rsp_info_t         rsp_q;
  logic [DWIDTH-1:0] rd_word_q;
  logic [DWIDTH-1:0] shifted_c;
  logic [DWIDTH-1:0] keep_c;
  logic              sbit_c;
  logic [DWIDTH-1:0] ext_c;

  assign req_ready = !rsp_valid || rsp_ready;
  assign accept_c  = req_valid && req_ready;
  assign rsp_err   = rsp_q.err;

  // Request decode: word index, lane, error classification, byte enables.
  always_comb begin
    idx_c        = req_addr[OFFW +: IDXW];
    lane_raw_c   = req_addr[OFFW-1:0];
    align_mask_c = OFFW'((32'd1 << req_size) - 32'd1);
    range_err_c  = ({1'b0, req_addr} >= MEM_BYTES);
    size_err_c   = (DWIDTH == 32) && (req_size == 2'd3);
`ifdef DATA_RAM_ALIGN_CHECK_EN
    lane_c       = lane_raw_c;
    align_err_c  = |(lane_raw_c & align_mask_c);
`else
    lane_c       = lane_raw_c & ~align_mask_c;
    align_err_c  = 1'b0;
`endif
    err_c        = range_err_c || size_err_c || align_err_c;

    be_base_c = '0;
    unique case (req_size)
      2'd0:    be_base_c = NB'(8'h01);
      2'd1:    be_base_c = NB'(8'h03);
      2'd2:    be_base_c = NB'(8'h0F);
      default: be_base_c = NB'(8'hFF);
    endcase
    be_c       = be_base_c << lane_c;
    wdata_sh_c = req_wdata << {lane_c, 3'b000};
    we_c       = accept_c && req_we && !err_c;
  end

  // RAM array: byte-enabled write, synchronous read captured on acceptance, no reset.
  always_ff @(posedge clk) begin
    if (we_c && rst_n) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (be_c[b]) mem[idx_c][b*8 +: 8] <= wdata_sh_c[b*8 +: 8];
      end
    end
    if (accept_c) rd_word_q <= mem[idx_c];
  end

  // Response handshake state; a new request can only land once the old one is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
    end else if (accept_c) begin
      rsp_valid     <= 1'b1;
      rsp_q.err     <= err_c;
      rsp_q.load_ok <= !req_we && !err_c;
      rsp_q.uns     <= req_unsigned;
      rsp_q.size    <= req_size;
      rsp_q.lane    <= lane_c;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // Load formatting: shift the addressed lane down, then sign- or zero-extend.
  always_comb begin
    shifted_c = rd_word_q >> {rsp_q.lane, 3'b000};
    keep_c    = '1;
    sbit_c    = 1'b0;
    unique case (rsp_q.size)
      2'd0: begin
        keep_c = DWIDTH'(8'hFF);
        sbit_c = shifted_c[7];
      end
      2'd1: begin
        keep_c = DWIDTH'(16'hFFFF);
        sbit_c = shifted_c[15];
      end
      2'd2: begin
        keep_c = DWIDTH'(32'hFFFF_FFFF);
        sbit_c = shifted_c[31];
      end
      default: begin
        keep_c = '1;
        sbit_c = 1'b0;
      end
    endcase
    ext_c     = (shifted_c & keep_c) | ((sbit_c && !rsp_q.uns) ? ~keep_c : '0);
    rsp_rdata = rsp_q.load_ok ? ext_c : '0;
  end

endmodule

// File: tb/tb_data_ram_ls.sv
// Scoreboard bench for data_ram_ls: byte-array reference model, directed cases and random traffic.
module tb_data_ram_ls;

  localparam int unsigned DW = 32;
  localparam int unsigned MEM_BYTES = 4096;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  data_ram_ls #(.DWIDTH(32), .MEMDEPTH(1024), .AWIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  typedef struct {
    bit          err;
    logic [31:0] data;
    string       nm;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mm [MEM_BYTES];
  int         checks = 0;
  int         errors = 0;
  int         rdy_mode = 0;   // 0: always ready, 1: random, 2: follow man_rdy
  bit         man_rdy = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: memory as a flat byte array, little-endian.
  function automatic void model(input bit we, input logic [1:0] size, input bit uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output bit err, output logic [31:0] data);
    int unsigned n = 32'd1 << size;
    logic [31:0] a = addr;
    err  = 1'b0;
    data = '0;
    if (a >= MEM_BYTES) err = 1'b1;
    if (size == 2'd3) err = 1'b1;
`ifdef DATA_RAM_ALIGN_CHECK_EN
    if ((a % n) != 0) err = 1'b1;
`else
    a = a - (a % n);
`endif
    if (err) return;
    if (we) begin
      for (int i = 0; i < int'(n); i++) mm[a + i] = wdata[8*i +: 8];
    end else begin
      for (int i = 0; i < int'(n); i++) data[8*i +: 8] = mm[a + i];
      if (!uns && data[8*n-1]) for (int i = 8*n; i < 32; i++) data[i] = 1'b1;
    end
  endfunction

  task automatic issue(input bit we, input logic [1:0] size, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input bit lit, input bit lerr, input logic [31:0] ldata,
                       input string nm, output int waited);
    exp_t e;
    bit   merr;
    logic [31:0] mdata;
    waited = 0;
    @(negedge clk);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    #1;
    while (!req_ready) begin
      waited++;
      if (waited > 200) begin
        checks++; errors++;
        $display("FAIL %s: req_ready stayed %0b for %0d cycles, required 1", nm, req_ready, waited);
        req_valid = 1'b0;
        return;
      end
      @(negedge clk); #1;
    end
    model(we, size, uns, addr, wdata, merr, mdata);
    e.err  = lit ? lerr : merr;
    e.data = lit ? ldata : mdata;
    e.nm   = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic op(input bit we, input logic [1:0] size, input bit uns,
                    input logic [31:0] addr, input logic [31:0] wdata, input string nm);
    int w;
    issue(we, size, uns, addr, wdata, 1'b0, 1'b0, 32'd0, nm, w);
  endtask

  task automatic opx(input bit we, input logic [1:0] size, input bit uns,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input bit lerr, input logic [31:0] ldata, input string nm);
    int w;
    issue(we, size, uns, addr, wdata, 1'b1, lerr, ldata, nm, w);
  endtask

  task automatic chk(input bit ok, input string nm, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, got, req);
    end
  endtask

  // Consumer back-pressure generator.
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = ($urandom % 4) != 0;
        default: rsp_ready = man_rdy;
      endcase
    end
  end

  // Monitor: pops the scoreboard on each handshake and checks hold stability while stalled.
  initial begin
    bit          held;
    logic [31:0] hd;
    bit          he;
    exp_t        e;
    held = 1'b0;
    forever begin
      @(negedge clk); #2;
      if (!rst_n) begin
        held = 1'b0;
        continue;
      end
      if (held) begin
        checks++;
        if (!rsp_valid || rsp_rdata !== hd || rsp_err !== he) begin
          errors++;
          $display("FAIL hold: got valid=%0b err=%0b data=%h, required valid=1 err=%0b data=%h",
                   rsp_valid, rsp_err, rsp_rdata, he, hd);
        end
      end
      held = 1'b0;
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: got err=%0b data=%h, required no response", rsp_err, rsp_rdata);
        end else begin
          e = exp_q.pop_front();
          if (rsp_err !== e.err || rsp_rdata !== e.data) begin
            errors++;
            $display("FAIL %s: got err=%0b data=%h, required err=%0b data=%h",
                     e.nm, rsp_err, rsp_rdata, e.err, e.data);
          end
        end
      end else if (rsp_valid) begin
        held = 1'b1;
        hd   = rsp_rdata;
        he   = rsp_err;
      end
    end
  end

  initial begin
    int          w;
    int          total_wait;
    logic [31:0] held_data;
    logic [31:0] a;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;

    #22;
    chk(rsp_valid == 1'b0, "reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk(rsp_err == 1'b0,   "reset_rsp_err",   32'(rsp_err),   32'd0);
    chk(rsp_rdata == '0,   "reset_rsp_rdata", rsp_rdata,      32'd0);
    chk(req_ready == 1'b1, "reset_req_ready", 32'(req_ready), 32'd1);
    #1 rst_n = 1'b1;

    // Fill every word back-to-back with rsp_ready high: no request may stall.
    total_wait = 0;
    for (int i = 0; i < 1024; i++) begin
      issue(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, 1'b0, 1'b0, 32'd0, "preload", w);
      total_wait += w;
    end
    chk(total_wait == 0, "throughput_stalls", 32'(total_wait), 32'd0);

    opx(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0, "sw_10");
    opx(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b0, 32'hFFFF_FFDE, "lb_13");
    opx(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b0, 32'h0000_00DE, "lbu_13");
    opx(1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344, 1'b0, 32'h0, "sw_20");
    opx(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000_AAAA, 1'b0, 32'h0, "sh_22");
    opx(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, 32'hAAAA_3344, "lw_20");
    opx(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 1'b1, 32'h0, "lw_oor");
    opx(1'b1, 2'd2, 1'b0, 32'h1000, 32'h5555_5555, 1'b1, 32'h0, "sw_oor");
    op(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, "lw_0_after_oor");
    opx(1'b1, 2'd3, 1'b0, 32'h40, 32'hFFFF_FFFF, 1'b1, 32'h0, "sd_illegal");
    op(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, "lw_40_after_illegal");
`ifdef DATA_RAM_ALIGN_CHECK_EN
    opx(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 1'b1, 32'h0, "lh_11_misaligned");
`else
    opx(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 1'b0, 32'hFFFF_BEEF, "lh_11_forced");
`endif
    op(1'b1, 2'd2, 1'b0, 32'h30, $urandom, "sw_30");
    op(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, "lw_30_raw");
    op(1'b1, 2'd0, 1'b0, 32'h31, $urandom, "sb_31");
    op(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, "lw_30_raw_byte");

    // Back-pressure: a load held for three cycles, then the next request on the first ready cycle.
    man_rdy = 1'b1;
    rdy_mode = 2;
    repeat (3) @(posedge clk);
    #1;
    opx(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, 32'hAAAA_3344, "lw_20_stalled");
    man_rdy = 1'b0;
    held_data = rsp_rdata;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      chk(rsp_valid == 1'b1, "stall_rsp_valid", 32'(rsp_valid), 32'd1);
      chk(rsp_rdata == held_data, "stall_rsp_rdata", rsp_rdata, held_data);
      chk(req_ready == 1'b0, "stall_req_ready", 32'(req_ready), 32'd0);
    end
    man_rdy = 1'b1;
    issue(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 1'b0, 1'b0, 32'd0, "lbu_10_after_stall", w);
    chk(w == 0, "first_ready_accept", 32'(w), 32'd0);

    // Reset while a response is pending: it is dropped and the memory is kept.
    repeat (3) @(posedge clk);
    #1;
    opx(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, "lw_10_pre_reset");
    man_rdy = 1'b0;
    @(negedge clk); #1;
    chk(rsp_valid == 1'b1, "pending_before_reset", 32'(rsp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk(rsp_valid == 1'b0, "async_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk(rsp_rdata == '0,   "async_reset_rsp_rdata", rsp_rdata, 32'd0);
    chk(req_ready == 1'b1, "async_reset_req_ready", 32'(req_ready), 32'd1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    rdy_mode = 0;
    opx(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, "lw_10_post_reset");
    op(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, "lw_20_post_reset");

    // Random traffic with random consumer back-pressure.
    rdy_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      int unsigned r = $urandom % 10;
      if (r == 0)     a = 32'(MEM_BYTES + ($urandom % MEM_BYTES));
      else if (r < 5) a = $urandom % 64;
      else            a = $urandom % MEM_BYTES;
      op(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, "random");
    end

    rdy_mode = 0;
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(posedge clk);
    chk(exp_q.size() == 0, "drain_outstanding", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
